// File: rtl/mac_tile_hybrid.sv
// Systolic MAC tile with `lanes` independent lanes. Runs weight-stationary
// (psums flow south) or output-stationary (accumulate in place, drain south).
module mac_tile_hybrid #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int lanes   = 2,
  parameter bit SAT     = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode,
  input  logic [bw*lanes-1:0]      in_w,
  output logic [bw*lanes-1:0]      out_e,
  input  logic [2:0]               inst_w,
  output logic [2:0]               inst_e,
  input  logic [psum_bw*lanes-1:0] in_n,
  output logic [psum_bw*lanes-1:0] out_s
);

  localparam int PW = 2 * bw + 1;

  // Unsigned activation times signed weight, added to psum with wrap or clamp.
  function automatic logic [psum_bw-1:0] mac_sum(
    input logic [psum_bw-1:0] psum,
    input logic [bw-1:0]      act,
    input logic [bw-1:0]      wgt
  );
    logic signed [PW-1:0]    prod;
    logic signed [psum_bw:0] wide;
    logic [psum_bw-1:0]      res;
    prod = PW'($signed({1'b0, act})) * PW'($signed(wgt));
    wide = (psum_bw+1)'($signed(psum)) + (psum_bw+1)'(prod);
    res  = wide[psum_bw-1:0];
    if (SAT && (wide[psum_bw] != wide[psum_bw-1])) begin
      res = wide[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
    end
    return res;
  endfunction

  logic [2:0] inst_d, inst_q;
  logic       load_ready_d, load_ready_q;
  logic       ws_load;

  always_comb begin
    ws_load      = 1'b0;
    load_ready_d = load_ready_q;
    inst_d       = inst_w;
    if (!mode) begin
      ws_load = inst_w[0] & load_ready_q;
      if (ws_load) begin
        load_ready_d = 1'b0;
      end
      // The first kernel word is kept by this tile; later ones travel east.
      inst_d = {1'b0, inst_w[1], inst_w[0] & ~load_ready_q};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q       <= '0;
      load_ready_q <= 1'b1;
    end else begin
      inst_q       <= inst_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign inst_e = inst_q;

  for (genvar gi = 0; gi < lanes; gi++) begin : g_lane
    logic [bw-1:0]      a_d, a_q, w_d, w_q, a_in, w_in;
    logic [psum_bw-1:0] psum_d, psum_q, n_in, s_out;

    assign a_in = in_w[gi*bw +: bw];
    assign n_in = in_n[gi*psum_bw +: psum_bw];
    assign w_in = n_in[bw-1:0];

    always_comb begin
      a_d    = a_q;
      w_d    = w_q;
      psum_d = psum_q;
      if (!mode) begin
        psum_d = n_in;
        if (inst_w[0] | inst_w[1]) begin
          a_d = a_in;
        end
        if (ws_load) begin
          w_d = a_in;
        end
      end else if (inst_w[2]) begin
        // Drain takes priority; a simultaneous execute is discarded entirely.
        psum_d = n_in;
      end else if (inst_w[1]) begin
        a_d    = a_in;
        w_d    = w_in;
        psum_d = mac_sum(psum_q, a_in, w_in);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        a_q    <= '0;
        w_q    <= '0;
        psum_q <= '0;
      end else begin
        a_q    <= a_d;
        w_q    <= w_d;
        psum_q <= psum_d;
      end
    end

    always_comb begin
      if (!mode) begin
        s_out = mac_sum(psum_q, a_q, w_q);
      end else if (inst_w[2]) begin
        s_out = psum_q;
      end else begin
        s_out = psum_bw'($signed(w_q));
      end
    end

    assign out_e[gi*bw +: bw]           = a_q;
    assign out_s[gi*psum_bw +: psum_bw] = s_out;
  end

endmodule

// File: tb/tb_mac_tile_hybrid.sv
// Self-checking bench for mac_tile_hybrid: vector table with a scoreboard queue,
// plus directed reset, saturation and 3-deep drain-column sequences.
module tb_mac_tile_hybrid;

  logic clk, reset;
  int   checks, failures;

  // Main tile: bw=4, psum_bw=16, lanes=2, wrap.
  logic        mode;
  logic [2:0]  inst_w, inst_e;
  logic [7:0]  in_w, out_e;
  logic [31:0] in_n, out_s;

  // Saturating and wrapping single-lane tiles with psum_bw=8.
  logic       s_mode;
  logic [2:0] s_inst, s1_inst_e, s0_inst_e;
  logic [3:0] s_in_w, s1_out_e, s0_out_e;
  logic [7:0] s_in_n, s1_out_s, s0_out_s;

  // Three-tile column.
  logic        c_mode, c_chain;
  logic [2:0]  c_inst;
  logic [15:0] c_w_n;
  logic [3:0]  c_a [3];
  logic [3:0]  c_e [3];
  logic [2:0]  c_ie [3];
  logic [15:0] c_n [3];
  logic [15:0] c_s [3];

  mac_tile_hybrid #(.bw(4), .psum_bw(16), .lanes(2), .SAT(1'b0)) dut (
    .clk(clk), .reset(reset), .mode(mode), .in_w(in_w), .out_e(out_e),
    .inst_w(inst_w), .inst_e(inst_e), .in_n(in_n), .out_s(out_s)
  );

  mac_tile_hybrid #(.bw(4), .psum_bw(8), .lanes(1), .SAT(1'b1)) u_sat1 (
    .clk(clk), .reset(reset), .mode(s_mode), .in_w(s_in_w), .out_e(s1_out_e),
    .inst_w(s_inst), .inst_e(s1_inst_e), .in_n(s_in_n), .out_s(s1_out_s)
  );

  mac_tile_hybrid #(.bw(4), .psum_bw(8), .lanes(1), .SAT(1'b0)) u_sat0 (
    .clk(clk), .reset(reset), .mode(s_mode), .in_w(s_in_w), .out_e(s0_out_e),
    .inst_w(s_inst), .inst_e(s0_inst_e), .in_n(s_in_n), .out_s(s0_out_s)
  );

  for (genvar gi = 0; gi < 3; gi++) begin : g_col
    if (gi == 0) begin : g_top
      assign c_n[gi] = c_chain ? 16'h0000 : c_w_n;
    end else begin : g_below
      assign c_n[gi] = c_chain ? c_s[gi-1] : c_w_n;
    end
    mac_tile_hybrid #(.bw(4), .psum_bw(16), .lanes(1), .SAT(1'b0)) u_tile (
      .clk(clk), .reset(reset), .mode(c_mode), .in_w(c_a[gi]), .out_e(c_e[gi]),
      .inst_w(c_inst), .inst_e(c_ie[gi]), .in_n(c_n[gi]), .out_s(c_s[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        mode;
    logic [2:0]  inst;
    logic [7:0]  in_w;
    logic [31:0] in_n;
    logic [7:0]  exp_e;
    logic [2:0]  exp_inst;
    logic [31:0] exp_s;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];
  vec_t exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic apply(input vec_t v);
    mode   = v.mode;
    inst_w = v.inst;
    in_w   = v.in_w;
    in_n   = v.in_n;
  endtask

  initial begin
    vec_t e;
    vec_t idle;
    int   vi;
    checks = 0; failures = 0;
    reset = 1'b1;
    mode = 1'b0; inst_w = 3'b000; in_w = '0; in_n = '0;
    s_mode = 1'b0; s_inst = 3'b000; s_in_w = '0; s_in_n = '0;
    c_mode = 1'b0; c_chain = 1'b0; c_inst = 3'b000; c_w_n = '0;
    for (int i = 0; i < 3; i++) c_a[i] = '0;

    // mode, inst, in_w, in_n  ->  out_e, inst_e, out_s seen one cycle later
    tbl[0]  = '{1'b0, 3'b001, 8'h3E, 32'h0000_0000, 8'h3E, 3'b000, 32'h0009_FFE4};
    tbl[1]  = '{1'b0, 3'b001, 8'h11, 32'h0000_0000, 8'h11, 3'b001, 32'h0003_FFFE};
    tbl[2]  = '{1'b0, 3'b010, 8'h57, 32'h0064_FFCE, 8'h57, 3'b010, 32'h0073_FFC0};
    tbl[3]  = '{1'b0, 3'b000, 8'h00, 32'h0000_0000, 8'h57, 3'b000, 32'h0003_FFFE};
    tbl[4]  = '{1'b1, 3'b010, 8'h12, 32'h0002_0001, 8'h12, 3'b010, 32'h0002_0001};
    tbl[5]  = '{1'b1, 3'b010, 8'h13, 32'h0002_000F, 8'h13, 3'b010, 32'h0002_FFFF};
    tbl[6]  = '{1'b1, 3'b010, 8'h14, 32'h0002_0005, 8'h14, 3'b010, 32'h0002_0005};
    tbl[7]  = '{1'b1, 3'b000, 8'h00, 32'h0000_0000, 8'h14, 3'b000, 32'h0006_0013};
    tbl[8]  = '{1'b1, 3'b100, 8'h00, 32'h0AAA_0BBB, 8'h14, 3'b100, 32'h0AAA_0BBB};
    tbl[9]  = '{1'b1, 3'b110, 8'h77, 32'h0123_0045, 8'h14, 3'b110, 32'h0123_0045};
    tbl[10] = '{1'b1, 3'b100, 8'h00, 32'h0000_0000, 8'h14, 3'b100, 32'h0000_0000};
    tbl[11] = '{1'b1, 3'b100, 8'h00, 32'h0000_0000, 8'h14, 3'b100, 32'h0002_0005};
    tbl[12] = '{1'b1, 3'b000, 8'h00, 32'h0000_0000, 8'h14, 3'b000, 32'h0002_0014};
    tbl[13] = '{1'b0, 3'b000, 8'h00, 32'h1234_0100, 8'h14, 3'b000, 32'h1236_0114};
    tbl[14] = '{1'b0, 3'b001, 8'h99, 32'h0000_0000, 8'h99, 3'b001, 32'h0012_002D};
    tbl[15] = '{1'b0, 3'b000, 8'h00, 32'h0000_0000, 8'h99, 3'b000, 32'h0012_002D};
    idle    = '{1'b0, 3'b000, 8'h00, 32'h0000_0000, 8'h00, 3'b000, 32'h0000_0000};

    // Reset state.
    #12;
    check("reset out_e", {24'h0, out_e}, 32'h0);
    check("reset inst_e", {29'h0, inst_e}, 32'h0);
    check("reset out_s", out_s, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Table with scoreboard: push at drive, pop one edge later.
    @(posedge clk); #1;
    apply(tbl[0]);
    exp_q.push_back(tbl[0]);
    vi = 0;
    for (int i = 1; i <= NV; i++) begin
      @(posedge clk); #1;
      if (i < NV) begin
        apply(tbl[i]);
        exp_q.push_back(tbl[i]);
      end else begin
        apply(idle);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("vec%0d out_e", vi), {24'h0, out_e}, {24'h0, e.exp_e});
      check($sformatf("vec%0d inst_e", vi), {29'h0, inst_e}, {29'h0, e.exp_inst});
      check($sformatf("vec%0d out_s", vi), out_s, e.exp_s);
      vi++;
    end

    // Reset between edges with live state, then reload the kernel.
    @(posedge clk); #1;
    mode = 1'b0; inst_w = 3'b010; in_w = 8'h99; in_n = '0;
    @(posedge clk);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("midreset out_e", {24'h0, out_e}, 32'h0);
    check("midreset inst_e", {29'h0, inst_e}, 32'h0);
    check("midreset out_s", out_s, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    inst_w = 3'b001; in_w = 8'h23;
    @(posedge clk); #1;
    inst_w = 3'b010; in_w = 8'h11;
    @(negedge clk);
    check("reload inst_e", {29'h0, inst_e}, 32'h0);
    check("reload out_e", {24'h0, out_e}, 32'h23);
    @(posedge clk); #1;
    inst_w = 3'b000; in_w = 8'h00;
    @(negedge clk);
    check("reload exec out_s", out_s, 32'h0002_0003);
    check("reload exec inst_e", {29'h0, inst_e}, 32'h2);

    // Saturation vs wrap, psum_bw=8.
    @(posedge clk); #1;
    s_mode = 1'b0; s_inst = 3'b001; s_in_w = 4'd7; s_in_n = 8'h00;
    @(posedge clk); #1;
    s_inst = 3'b010; s_in_w = 4'd15; s_in_n = 8'd120;
    @(posedge clk); #1;
    s_inst = 3'b000; s_in_w = 4'd0; s_in_n = 8'h00;
    @(negedge clk);
    check("ws sat pos", {24'h0, s1_out_s}, 32'h7F);
    check("ws wrap pos", {24'h0, s0_out_s}, 32'hE1);
    @(posedge clk); #1;
    s_mode = 1'b1; s_inst = 3'b100; s_in_n = 8'd120;
    @(posedge clk); #1;
    s_inst = 3'b010; s_in_w = 4'd15; s_in_n = 8'h07;
    @(posedge clk); #1;
    s_inst = 3'b100; s_in_w = 4'd0; s_in_n = 8'h88;
    @(negedge clk);
    check("os sat pos", {24'h0, s1_out_s}, 32'h7F);
    check("os wrap pos", {24'h0, s0_out_s}, 32'hE1);
    @(posedge clk); #1;
    s_inst = 3'b010; s_in_w = 4'd15; s_in_n = 8'h08;
    @(posedge clk); #1;
    s_inst = 3'b100; s_in_w = 4'd0; s_in_n = 8'h00;
    @(negedge clk);
    check("os sat neg", {24'h0, s1_out_s}, 32'h80);
    check("os wrap neg", {24'h0, s0_out_s}, 32'h10);
    @(posedge clk); #1;
    s_inst = 3'b000;

    // Drain column: accumulate 10/20/30 top to bottom, then shift out.
    @(posedge clk); #1;
    c_mode = 1'b1; c_inst = 3'b010; c_chain = 1'b0; c_w_n = 16'h0002;
    c_a[0] = 4'd5; c_a[1] = 4'd10; c_a[2] = 4'd15;
    @(posedge clk); #1;
    c_inst = 3'b100; c_chain = 1'b1;
    for (int i = 0; i < 3; i++) c_a[i] = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("drain cycle%0d bottom", k), {16'h0, c_s[2]}, 32'(30 - 10 * k));
      @(posedge clk); #1;
    end
    @(negedge clk);
    for (int t = 0; t < 3; t++) begin
      check($sformatf("drained tile%0d acc", t), {16'h0, c_s[t]}, 32'h0);
    end
    @(posedge clk); #1;
    c_inst = 3'b000;
    @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
